// File: rtl/wb_resp_pkg.sv
// Shared types and constants for the Wishbone memory responder.
package wb_resp_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    // LFSR seed and Fibonacci tap mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // IDLE: waiting for cyc&stb; WAIT: counting wait states; TERM: ack/err cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TERM = 2'd2
    } resp_state_t;

    // One step of the shift-left Fibonacci LFSR: feedback is the XOR of the tapped bits
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/wb_resp_ram.sv
// Single-port RAM, 32-bit words, per-byte write enables, registered read data.
module wb_resp_ram #(
    parameter int AW = 10
) (
    input  logic                               clk_i,
    input  logic [AW-1:0]                      addr_i,
    input  logic [wb_resp_pkg::WB_SELW-1:0]    we_i,
    input  logic [wb_resp_pkg::WB_DW-1:0]      wdata_i,
    input  logic                               re_i,
    output logic [wb_resp_pkg::WB_DW-1:0]      rdata_o
);
    import wb_resp_pkg::*;

    logic [WB_DW-1:0] mem_q [2**AW];
    logic [WB_DW-1:0] rdata_q;

    // Byte-lane writes and synchronous read; contents are never reset
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < WB_SELW; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic slave backed by a byte-enabled RAM, with fixed and
// optional LFSR-driven wait states, range checking and completion counters.
//
// Handshake: a request is cyc&stb sampled in IDLE; the request is latched
// and the bus inputs are then ignored except for cyc&stb, whose drop during
// WAIT aborts the access. Exactly one of ack/err pulses for the single TERM
// cycle; the FSM always passes through IDLE before sampling a new request,
// so terminations are never back to back.
module wb_mem_responder #(
    parameter int MEM_AW   = 10,
    parameter int RD_WAIT  = 3,
    parameter int WR_WAIT  = 1,
    parameter int STALL_EN = 0
) (
    input  logic        sys_clk,
    input  logic        RESETN,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        busy_o,
    output logic [15:0] wr_cnt_o,
    output logic [15:0] rd_cnt_o
);
    import wb_resp_pkg::*;

    localparam logic [4:0] RD_W = 5'(RD_WAIT);
    localparam logic [4:0] WR_W = 5'(WR_WAIT);

    resp_state_t        state_q;
    logic [4:0]         cnt_q;
    logic [7:0]         lfsr_q;
    logic [31:0]        req_addr_q;
    logic               req_we_q;
    logic [3:0]         req_sel_q;
    logic [31:0]        req_dat_q;
    logic               ack_q;
    logic               err_q;
    logic               rd_valid_q;
    logic [15:0]        wr_cnt_q;
    logic [15:0]        rd_cnt_q;

    logic               req;
    logic [4:0]         cnt_d;
    logic               addr_oor;
    logic               term_go;
    logic [3:0]         ram_we;
    logic               ram_re;
    logic [31:0]        ram_rdata;

    assign req = wb_cyc_i & wb_stb_i;

    // Wait count chosen at accept time from direction plus optional stall
    always_comb begin
        cnt_d = wb_we_i ? WR_W : RD_W;
        if (STALL_EN != 0) begin
            cnt_d = cnt_d + {3'b000, lfsr_q[1:0]};
        end
    end

    // Any address bit at or above MEM_AW makes the access out of range
    assign addr_oor = (req_addr_q >> MEM_AW) != 32'd0;

    // Last WAIT cycle with the request still present: access completes here
    assign term_go = (state_q == WAIT) && req && (cnt_q == 5'd0);

    // RAM is accessed on the edge entering TERM; reset blocks a pending write
    assign ram_we = (term_go && !addr_oor && req_we_q && RESETN) ? req_sel_q : 4'b0000;
    assign ram_re = term_go && !addr_oor && !req_we_q;

    wb_resp_ram #(
        .AW(MEM_AW)
    ) u_ram (
        .clk_i   (sys_clk),
        .addr_i  (req_addr_q[MEM_AW-1:0]),
        .we_i    (ram_we),
        .wdata_i (req_dat_q),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    // Request FSM with wait counter, LFSR, registered terminations and counters
    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            lfsr_q     <= LFSR_SEED;
            req_addr_q <= 32'd0;
            req_we_q   <= 1'b0;
            req_sel_q  <= 4'd0;
            req_dat_q  <= 32'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_cnt_q   <= 16'd0;
            rd_cnt_q   <= 16'd0;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        req_addr_q <= wb_addr_i;
                        req_we_q   <= wb_we_i;
                        req_sel_q  <= wb_sel_i;
                        req_dat_q  <= wb_dat_i;
                        cnt_q      <= cnt_d;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 5'd0) begin
                        state_q <= TERM;
                        if (addr_oor) begin
                            err_q      <= 1'b1;
                            rd_valid_q <= 1'b0;
                        end else begin
                            ack_q <= 1'b1;
                            if (req_we_q) begin
                                if (wr_cnt_q != 16'hFFFF) begin
                                    wr_cnt_q <= wr_cnt_q + 16'd1;
                                end
                            end else begin
                                rd_valid_q <= 1'b1;
                                if (rd_cnt_q != 16'hFFFF) begin
                                    rd_cnt_q <= rd_cnt_q + 16'd1;
                                end
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                TERM: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = rd_valid_q ? ram_rdata : 32'd0;
    assign busy_o   = (state_q != IDLE);
    assign wr_cnt_o = wr_cnt_q;
    assign rd_cnt_o = rd_cnt_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: two instances (fixed waits / LFSR stalls),
// directed and random accesses checked against a word-level memory model.
module tb_wb_mem_responder;

  localparam int AW0 = 15, RDW0 = 3, WRW0 = 1;
  localparam int AW1 = 10, RDW1 = 2, WRW1 = 3;

  int aw_c[2]    = '{AW0, AW1};
  int rd_w[2]    = '{RDW0, RDW1};
  int wr_w[2]    = '{WRW0, WRW1};
  int stall_m[2] = '{0, 3};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstn;
  logic [1:0]  cyc, stb, we;
  logic [3:0]  sel  [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic [1:0]  ack, err, busy;
  logic [15:0] wrc  [2];
  logic [15:0] rdc  [2];

  wb_mem_responder #(.MEM_AW(AW0), .RD_WAIT(RDW0), .WR_WAIT(WRW0), .STALL_EN(0)) dut0 (
    .sys_clk(clk), .RESETN(rstn[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_addr_i(addr[0]), .wb_dat_i(wdat[0]),
    .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .busy_o(busy[0]),
    .wr_cnt_o(wrc[0]), .rd_cnt_o(rdc[0])
  );

  wb_mem_responder #(.MEM_AW(AW1), .RD_WAIT(RDW1), .WR_WAIT(WRW1), .STALL_EN(1)) dut1 (
    .sys_clk(clk), .RESETN(rstn[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_addr_i(addr[1]), .wb_dat_i(wdat[1]),
    .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .busy_o(busy[1]),
    .wr_cnt_o(wrc[1]), .rd_cnt_o(rdc[1])
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [longint];
  int wr_exp[2] = '{0, 0};
  int rd_exp[2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic longint mkey(input int d, input logic [31:0] a);
    return (longint'(d) << 32) | longint'(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Terminations must never be back to back, and ack/err never together
  logic [1:0] prev_term = 2'b00;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack[d] || err[d]) begin
        check("b2b_term", 32'(prev_term[d]), 32'd0);
        check("ack_err_excl", 32'(ack[d] & err[d]), 32'd0);
      end
      prev_term[d] = ack[d] | err[d];
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one request, scrambles non-handshake inputs while waiting,
  // and reports the latency in cycles counted from the accepting edge.
  task automatic bus_access(input int d, input logic w, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] dat,
                            output int lat, output logic g_ack, output logic g_err,
                            output logic [31:0] rd, output logic [15:0] wc,
                            output logic [15:0] rc);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdat[d] = dat;
    lat = 0; g_ack = 1'b0; g_err = 1'b0;
    while (!g_ack && !g_err && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      g_ack = ack[d];
      g_err = err[d];
      if (!g_ack && !g_err) begin
        we[d] = 1'($urandom_range(0, 1)); addr[d] = $urandom; sel[d] = 4'($urandom_range(0, 15));
        wdat[d] = $urandom;
      end
    end
    rd = rdat[d]; wc = wrc[d]; rc = rdc[d];
    cyc[d] = 1'b0; stb[d] = 1'b0;
    if (!g_ack && !g_err) check("term_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic do_op(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] dat, input string tag, output logic [31:0] rd);
    int lat, lo, hi;
    logic g_ack, g_err, oor;
    logic [15:0] wc, rc;
    logic [31:0] e;
    oor = (a >> aw_c[d]) != 0;
    if (!w && !oor) exp_q.push_back(ref_mem[mkey(d, a)]);
    bus_access(d, w, a, s, dat, lat, g_ack, g_err, rd, wc, rc);
    lo = (w ? wr_w[d] : rd_w[d]) + 2;
    hi = lo + stall_m[d];
    if (lo == hi) check({tag, "_lat"}, 32'(lat), 32'(lo));
    else          check({tag, "_lat_rng"}, 32'(lat >= lo && lat <= hi), 32'd1);
    check({tag, "_ack"}, 32'(g_ack), 32'(!oor));
    check({tag, "_err"}, 32'(g_err), 32'(oor));
    if (oor) begin
      check({tag, "_oor_dat"}, rd, 32'd0);
    end else if (w) begin
      e = ref_mem.exists(mkey(d, a)) ? ref_mem[mkey(d, a)] : 32'd0;
      ref_mem[mkey(d, a)] = merge(e, dat, s);
      if (wr_exp[d] < 65535) wr_exp[d]++;
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdat"}, rd, e);
      if (rd_exp[d] < 65535) rd_exp[d]++;
    end
    check({tag, "_wrcnt"}, 32'(wc), 32'(wr_exp[d]));
    check({tag, "_rdcnt"}, 32'(rc), 32'(rd_exp[d]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, v;
    logic [3:0] s;
    logic w;
    logic any_term;

    rstn = 2'b00; cyc = 2'b00; stb = 2'b00; we = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr[d] = 32'd0; sel[d] = 4'd0; wdat[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ack", 32'(ack[d]), 32'd0);
      check("rst_err", 32'(err[d]), 32'd0);
      check("rst_dat", rdat[d], 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_wrc", 32'(wrc[d]), 32'd0);
      check("rst_rdc", 32'(rdc[d]), 32'd0);
    end
    rstn = 2'b11;

    // Basic write / read on the fixed-wait instance
    do_op(0, 1'b1, 32'h0000_4000, 4'hF, 32'hDEADBEEF, "wr_basic", rd);
    do_op(0, 1'b0, 32'h0000_4000, 4'hF, 32'h0, "rd_basic", rd);
    check("rd_basic_const", rd, 32'hDEADBEEF);

    // Byte lanes, then an all-lanes-off write that must change nothing
    do_op(0, 1'b1, 32'h0000_4001, 4'hF, 32'hAABBCCDD, "wr_lane_pre", rd);
    do_op(0, 1'b1, 32'h0000_4001, 4'b0101, 32'h11223344, "wr_lane", rd);
    do_op(0, 1'b0, 32'h0000_4001, 4'hF, 32'h0, "rd_lane", rd);
    check("rd_lane_const", rd, 32'hAA22CC44);
    do_op(0, 1'b1, 32'h0000_4001, 4'h0, 32'h55667788, "wr_sel0", rd);
    do_op(0, 1'b0, 32'h0000_4001, 4'hF, 32'h0, "rd_sel0", rd);
    check("rd_sel0_const", rd, 32'hAA22CC44);

    // Burst of 15 writes then 15 reads
    for (int i = 0; i < 15; i++) do_op(0, 1'b1, 32'h3F0 + 32'(i), 4'hF, $urandom, "burst_wr", rd);
    for (int i = 0; i < 15; i++) do_op(0, 1'b0, 32'h3F0 + 32'(i), 4'hF, 32'h0, "burst_rd", rd);

    // Out of range: must not alias onto word 0
    do_op(0, 1'b1, 32'h0000_0000, 4'hF, 32'hCAFE0001, "oor_pre", rd);
    do_op(0, 1'b0, 32'h0000_4000, 4'hF, 32'h0, "oor_pre_rd", rd);
    do_op(0, 1'b1, 32'h0001_0000, 4'hF, 32'hFFFFFFFF, "oor_wr", rd);
    do_op(0, 1'b0, 32'h0001_0000, 4'hF, 32'h0, "oor_rd", rd);
    do_op(0, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0, "oor_rd_top", rd);
    do_op(0, 1'b0, 32'h0000_0000, 4'hF, 32'h0, "oor_alias_rd", rd);
    check("oor_alias_const", rd, 32'hCAFE0001);

    // Abort on the stalling instance
    do_op(1, 1'b1, 32'd5, 4'hF, 32'h12345678, "ab_pre", rd);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'd5; sel[1] = 4'hF; wdat[1] = 32'h0BAD0BAD;
    @(posedge clk);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    any_term = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      any_term = any_term | ack[1] | err[1];
    end
    check("abort_no_term", 32'(any_term), 32'd0);
    check("abort_wrc", 32'(wrc[1]), 32'(wr_exp[1]));
    do_op(1, 1'b0, 32'd5, 4'hF, 32'h0, "abort_rd", rd);
    check("abort_rd_const", rd, 32'h12345678);

    // Random traffic with LFSR stalls; first touch of a word is a full write
    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      v = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        a = (32'($urandom_range(1, 4095)) << 10) | 32'($urandom_range(0, 1023));
      end else begin
        a = 32'($urandom_range(8, 63));
        if (!ref_mem.exists(mkey(1, a))) begin
          w = 1'b1;
          s = 4'hF;
        end
      end
      do_op(1, w, a, s, v, "rand", rd);
    end

    // Reset during WAIT of a write: abandoned, outputs cleared, RAM untouched
    do_op(1, 1'b0, 32'd5, 4'hF, 32'h0, "rst_pre_rd", rd);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'd5; sel[1] = 4'hF; wdat[1] = 32'hFEEDFACE;
    @(posedge clk);
    @(negedge clk);
    rstn[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ack", 32'(ack[1]), 32'd0);
    check("midrst_err", 32'(err[1]), 32'd0);
    check("midrst_dat", rdat[1], 32'd0);
    check("midrst_busy", 32'(busy[1]), 32'd0);
    check("midrst_wrc", 32'(wrc[1]), 32'd0);
    check("midrst_rdc", 32'(rdc[1]), 32'd0);
    rstn[1] = 1'b1;
    wr_exp[1] = 0;
    rd_exp[1] = 0;
    do_op(1, 1'b0, 32'd5, 4'hF, 32'h0, "postrst_rd", rd);
    check("postrst_rd_const", rd, 32'h12345678);
    do_op(1, 1'b1, 32'd6, 4'hF, 32'h600DF00D, "postrst_wr", rd);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
